// File: rtl/rv32i_ctrl_pkg.sv
// Shared control definitions for the RV32I pipeline: FSM encodings, register/opcode
// constants and the sequencer output bundle.
package rv32i_ctrl_pkg;

  localparam logic [1:0] ENC_RUN      = 2'd0;
  localparam logic [1:0] ENC_FLUSH    = 2'd1;
  localparam logic [1:0] ENC_MEM_WAIT = 2'd2;
  localparam logic [1:0] ENC_HALT     = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = ENC_RUN,
    ST_FLUSH    = ENC_FLUSH,
    ST_MEM_WAIT = ENC_MEM_WAIT,
    ST_HALT     = ENC_HALT
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic en_pc;
    logic if_id_en;
    logic nop_ins;
    logic if_id_flush;
    logic pipe_stall;
  } ctrl_out_t;

  localparam ctrl_out_t CO_RUN   = '{en_pc: 1'b1, if_id_en: 1'b1, nop_ins: 1'b0, if_id_flush: 1'b0, pipe_stall: 1'b0};
  localparam ctrl_out_t CO_MEMW  = '{en_pc: 1'b0, if_id_en: 1'b0, nop_ins: 1'b0, if_id_flush: 1'b0, pipe_stall: 1'b1};
  localparam ctrl_out_t CO_FLUSH = '{en_pc: 1'b1, if_id_en: 1'b1, nop_ins: 1'b1, if_id_flush: 1'b1, pipe_stall: 1'b0};
  localparam ctrl_out_t CO_HOLD  = '{en_pc: 1'b0, if_id_en: 1'b0, nop_ins: 1'b1, if_id_flush: 1'b0, pipe_stall: 1'b0};
  localparam ctrl_out_t CO_RESET = '{en_pc: 1'b0, if_id_en: 1'b0, nop_ins: 1'b1, if_id_flush: 1'b1, pipe_stall: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and pipeline control outputs between the datapath and the sequencer.
interface pipeline_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] ex_rd;
  logic       ex_is_load;
  logic       ex_pc_change;
  logic       undef_instr;
  logic       dmem_req;
  logic       dmem_ready;
  logic       trap_clr;
  logic       EN_PC;
  logic       if_id_en;
  logic       NOP_Ins;
  logic       if_id_flush;
  logic       pipe_stall;
  logic       halted;
  logic       mem_err;

  // datapath side
  modport master (
    output id_rs1, id_rs2, ex_rd, ex_is_load, ex_pc_change, undef_instr,
           dmem_req, dmem_ready, trap_clr,
    input  EN_PC, if_id_en, NOP_Ins, if_id_flush, pipe_stall, halted, mem_err
  );

  // sequencer side
  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_is_load, ex_pc_change, undef_instr,
           dmem_req, dmem_ready, trap_clr,
    output EN_PC, if_id_en, NOP_Ins, if_id_flush, pipe_stall, halted, mem_err
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX writes a register that the instruction in ID reads.
module hazard_detect
  import rv32i_ctrl_pkg::*;
(
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       lu_hazard
);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign lu_hazard = ex_is_load & (ex_rd != REG_X0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// RV32I 5-stage pipeline sequencer: load-use bubbles, branch redirect flush, data memory
// wait with timeout, and halt on undefined instruction until trap_clr.
module pipeline_ctrl
  import rv32i_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_W        = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  pipeline_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             halted_q, mem_err_q, err_set;
  logic             lu_hazard, mem_stall, run_eval;
  ctrl_out_t        o;

  hazard_detect u_hazard (
    .ex_is_load (bus.ex_is_load),
    .ex_rd      (bus.ex_rd),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .lu_hazard  (lu_hazard)
  );

  assign mem_stall = bus.dmem_req & ~bus.dmem_ready;
  // The cycle memory completes is an ordinary RUN cycle: EX unfreezes, so a held redirect
  // is taken right here rather than one cycle late.
  assign run_eval  = (state == ST_RUN) | ((state == ST_MEM_WAIT) & bus.dmem_ready);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      cnt       <= '0;
      halted_q  <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      halted_q <= (state_nxt == ST_HALT);
      if (err_set)           mem_err_q <= 1'b1;
      else if (bus.trap_clr) mem_err_q <= 1'b0;
    end
  end

  always_comb begin
    o         = CO_RUN;
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    if (run_eval) begin
      state_nxt = ST_RUN;
      cnt_nxt   = '0;
      if (mem_stall) begin
        o         = CO_MEMW;
        state_nxt = ST_MEM_WAIT;
        cnt_nxt   = CNT_ONE;
      end else if (bus.ex_pc_change) begin
        o         = CO_FLUSH;
        state_nxt = ST_FLUSH;
        cnt_nxt   = FLUSH_LD;
      end else if (bus.undef_instr) begin
        o         = CO_HOLD;
        state_nxt = ST_HALT;
      end else if (lu_hazard) begin
        o = CO_HOLD;
      end
    end else begin
      case (state)
        ST_MEM_WAIT: begin
          o = CO_MEMW;
          if (cnt == TIMEOUT) begin
            state_nxt = ST_HALT;
            err_set   = 1'b1;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
        ST_FLUSH: begin
          o = CO_FLUSH;
          if (bus.ex_pc_change) begin
            cnt_nxt = FLUSH_LD;
          end else if (cnt <= CNT_ONE) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        ST_HALT: begin
          // older instructions keep draining; only fetch/decode are held
          o = CO_HOLD;
          if (bus.trap_clr) begin
            state_nxt = ST_FLUSH;
            cnt_nxt   = FLUSH_LD;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
    if (!rst_n) o = CO_RESET;
  end

  assign bus.EN_PC       = o.en_pc;
  assign bus.if_id_en    = o.if_id_en;
  assign bus.NOP_Ins     = o.nop_ins;
  assign bus.if_id_flush = o.if_id_flush;
  assign bus.pipe_stall  = o.pipe_stall;
  assign bus.halted      = halted_q;
  assign bus.mem_err     = mem_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=15). Inputs change on the
// falling edge; outputs are sampled 1 time unit later.
module tb_pipeline_ctrl;

  // {EN_PC, if_id_en, NOP_Ins, if_id_flush, pipe_stall}
  localparam logic [4:0] V_RUN   = 5'b11000;
  localparam logic [4:0] V_HOLD  = 5'b00100;
  localparam logic [4:0] V_MEMW  = 5'b00001;
  localparam logic [4:0] V_FLUSH = 5'b11110;
  localparam logic [4:0] V_RESET = 5'b00110;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  pipeline_ctrl_if bus();

  pipeline_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .CLK   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [4:0] outs;
  assign outs = {bus.EN_PC, bus.if_id_en, bus.NOP_Ins, bus.if_id_flush, bus.pipe_stall};

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.id_rs1       = 5'd0;
    bus.id_rs2       = 5'd0;
    bus.ex_rd        = 5'd0;
    bus.ex_is_load   = 1'b0;
    bus.ex_pc_change = 1'b0;
    bus.undef_instr  = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_ready   = 1'b1;
    bus.trap_clr     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("reset_outs", outs, V_RESET);
    chk("reset_halted", {4'b0, bus.halted}, 5'd0);
    chk("reset_mem_err", {4'b0, bus.mem_err}, 5'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("run_default", outs, V_RUN);

    // load-use via rs2, then hazard gone
    @(negedge clk); bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_rs1 = 5'd3; #1;
    chk("lu_rs2_stall", outs, V_HOLD);
    @(negedge clk); idle(); #1;
    chk("lu_rs2_after", outs, V_RUN);
    // load-use via rs1
    @(negedge clk); bus.ex_is_load = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; #1;
    chk("lu_rs1_stall", outs, V_HOLD);
    // same register match but not a load
    @(negedge clk); bus.ex_is_load = 1'b0; #1;
    chk("nonload_match", outs, V_RUN);
    // x0 load
    @(negedge clk); idle(); bus.ex_is_load = 1'b1; #1;
    chk("x0_load", outs, V_RUN);

    // redirect: event + 2 flush cycles; undef during flush ignored
    @(negedge clk); idle(); bus.ex_pc_change = 1'b1; #1;
    chk("redir_event", outs, V_FLUSH);
    @(negedge clk); bus.ex_pc_change = 1'b0; bus.undef_instr = 1'b1; #1;
    chk("redir_flush1", outs, V_FLUSH);
    @(negedge clk); #1;
    chk("redir_flush2", outs, V_FLUSH);
    @(negedge clk); bus.undef_instr = 1'b0; #1;
    chk("redir_done", outs, V_RUN);
    chk("redir_no_halt", {4'b0, bus.halted}, 5'd0);

    // memory wait 4 cycles with a pending redirect
    @(negedge clk); bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; bus.ex_pc_change = 1'b1; #1;
    chk("memw_c1", outs, V_MEMW);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("memw_c%0d", i), outs, V_MEMW);
    end
    @(negedge clk); bus.dmem_ready = 1'b1; #1;
    chk("memw_redirect", outs, V_FLUSH);
    @(negedge clk); idle(); #1;
    chk("memw_flush1", outs, V_FLUSH);
    @(negedge clk); #1;
    chk("memw_flush2", outs, V_FLUSH);
    @(negedge clk); #1;
    chk("memw_run", outs, V_RUN);

    // timeout: 16 stalled cycles then HALT with mem_err
    @(negedge clk); bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; #1;
    chk("to_c1", outs, V_MEMW);
    for (int i = 2; i <= 16; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to_c%0d", i), outs, V_MEMW);
    end
    chk("to_c16_halted", {4'b0, bus.halted}, 5'd0);
    chk("to_c16_err", {4'b0, bus.mem_err}, 5'd0);
    @(negedge clk); bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1; #1;
    chk("to_halted", {4'b0, bus.halted}, 5'd1);
    chk("to_mem_err", {4'b0, bus.mem_err}, 5'd1);
    chk("to_halt_outs", outs, V_HOLD);
    @(negedge clk); bus.trap_clr = 1'b1; #1;
    chk("trap_cycle_outs", outs, V_HOLD);
    chk("trap_cycle_halted", {4'b0, bus.halted}, 5'd1);
    @(negedge clk); bus.trap_clr = 1'b0; #1;
    chk("trap_halted_clr", {4'b0, bus.halted}, 5'd0);
    chk("trap_err_clr", {4'b0, bus.mem_err}, 5'd0);
    chk("trap_flush1", outs, V_FLUSH);
    @(negedge clk); #1;
    chk("trap_flush2", outs, V_FLUSH);
    @(negedge clk); #1;
    chk("trap_run", outs, V_RUN);

    // undef has priority over load-use; halt then async reset mid-HALT
    @(negedge clk); bus.undef_instr = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9; #1;
    chk("undef_outs", outs, V_HOLD);
    chk("undef_not_yet", {4'b0, bus.halted}, 5'd0);
    @(negedge clk); idle(); #1;
    chk("undef_halted", {4'b0, bus.halted}, 5'd1);
    chk("undef_halt_outs", outs, V_HOLD);
    #2 rst_n = 1'b0; #1;
    chk("rst_mid_halted", {4'b0, bus.halted}, 5'd0);
    chk("rst_mid_outs", outs, V_RESET);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_release", outs, V_RUN);
    @(negedge clk); #1;
    chk("rst_first_edge", outs, V_RUN);
    chk("rst_first_halted", {4'b0, bus.halted}, 5'd0);

    // reset during FLUSH leaves no pending redirect
    @(negedge clk); bus.ex_pc_change = 1'b1; #1;
    chk("fl_rst_event", outs, V_FLUSH);
    @(negedge clk); bus.ex_pc_change = 1'b0; #1;
    chk("fl_rst_flush", outs, V_FLUSH);
    #2 rst_n = 1'b0; #1;
    chk("fl_rst_outs", outs, V_RESET);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("fl_rst_run", outs, V_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
